// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the two-producer FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned BURST_MAX_DEF = 4;
  localparam int unsigned BCNT_W        = 4;
  localparam int unsigned STAT_W        = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= INIT;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Two-producer burst arbiter feeding one shared FIFO write port.
// Define FIFO_ARB_STATS_EN to add per-producer accepted-beat counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  input  logic              fifo_full,
  output logic [1:0]        owner
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
`endif
);

  localparam logic [BCNT_W-1:0] BURST_LIM = BCNT_W'(BURST_MAX);

  arb_state_e        state_q, state_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic              last_q, last_d;   // 0 = req0 last granted, 1 = req1
  logic              own_sel;
  logic              own_valid;
  logic              oth_valid;
  logic              accept;
  logic              release_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    owner      = 2'b00;
    own_sel    = (state_q == GRANT1);
    own_valid  = 1'b0;
    oth_valid  = 1'b0;
    accept     = 1'b0;
    release_c  = 1'b0;

    case (state_q)
      GRANT0, GRANT1: begin
        own_valid  = own_sel ? req1_valid : req0_valid;
        oth_valid  = own_sel ? req0_valid : req1_valid;
        owner      = own_sel ? 2'b10 : 2'b01;
        req0_ready = !own_sel && !fifo_full;
        req1_ready = own_sel && !fifo_full;
        fifo_din   = own_sel ? req1_data : req0_data;
        accept     = own_valid && !fifo_full;
        fifo_wr_en = accept;
        release_c  = !own_valid || (accept && (BCNT_W'(cnt_q + BCNT_W'(1)) == BURST_LIM));
        if (accept) begin
          cnt_d = BCNT_W'(cnt_q + BCNT_W'(1));
        end
        // Prefer handing over to a waiting peer; otherwise restart own burst.
        if (release_c) begin
          cnt_d = '0;
          if (oth_valid) begin
            state_d = own_sel ? GRANT0 : GRANT1;
            last_d  = !own_sel;
          end else if (own_valid) begin
            state_d = state_q;
            last_d  = own_sel;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        if (req0_valid && (!req1_valid || last_q)) begin
          state_d = GRANT0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (req1_valid) begin
          state_d = GRANT1;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end
    endcase
  end

`ifdef FIFO_ARB_STATS_EN
  sat_counter #(.WIDTH(STAT_W)) u_stat0 (
    .clk   (clk),
    .rst   (rst),
    .inc_i (req0_valid && req0_ready),
    .cnt_o (grant_cnt0)
  );

  sat_counter #(.WIDTH(STAT_W)) u_stat1 (
    .clk   (clk),
    .rst   (rst),
    .inc_i (req1_valid && req1_ready),
    .cnt_o (grant_cnt1)
  );
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; stats checks follow FIFO_ARB_STATS_EN.
module tb_fifo_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       fifo_wr_en;
  logic [7:0] fifo_din;
  logic       fifo_full;
  logic [1:0] owner;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
  logic        sat_inc;
  logic [15:0] sat_cnt;
`endif

  int         n_chk = 0;
  int         n_bad = 0;
  logic [7:0] got[$];
  int         gcyc[$];

  logic [7:0] sp_v[3]   = '{8'hA1, 8'hB2, 8'hC3};
  logic [7:0] cont_v[16] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23,
                             8'h14, 8'h15, 8'h16, 8'h17, 8'h24, 8'h25, 8'h26, 8'h27};
  logic [7:0] full_v[6] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41};
  logic [7:0] drop_v[3] = '{8'h50, 8'h60, 8'h61};

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_W(8), .BURST_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .owner      (owner)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

`ifdef FIFO_ARB_STATS_EN
  sat_counter #(.WIDTH(16), .INIT(16'hFFFD)) u_sat (
    .clk   (clk),
    .rst   (rst),
    .inc_i (sat_inc),
    .cnt_o (sat_cnt)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    fifo_full  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Producers offer base+i beats; fifo_full is raised for full_len cycles from full_at.
  task automatic run(input int n0, input int s0, input logic [7:0] b0,
                     input int n1, input logic [7:0] b1,
                     input int full_at, input int full_len, input int max_cyc);
    int i0 = 0;
    int i1 = 0;
    int cyc = 0;
    bit stall;
    got.delete();
    gcyc.delete();
    while ((i0 < n0 || i1 < n1) && cyc < max_cyc) begin
      tick();
      stall      = (cyc >= full_at) && (cyc < full_at + full_len);
      req0_valid = (cyc >= s0) && (i0 < n0);
      req0_data  = b0 + 8'(i0);
      req1_valid = (i1 < n1);
      req1_data  = b1 + 8'(i1);
      fifo_full  = stall;
      #1;
      if (stall) begin
        check("stall_wr_en", 32'(fifo_wr_en), 32'd0);
        check("stall_ready", 32'({req0_ready, req1_ready}), 32'd0);
      end
      if (fifo_wr_en) begin
        got.push_back(fifo_din);
        gcyc.push_back(cyc);
      end
      if (req0_valid && req0_ready) i0++;
      if (req1_valid && req1_ready) i1++;
      cyc++;
    end
    check("all_beats", 32'(i0 + i1), 32'(n0 + n1));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    fifo_full  = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    fifo_full  = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    sat_inc    = 1'b0;
`endif

    // Reset holds everything idle even with both producers requesting
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);

    // Single producer: A1,B2,C3
    tick();
    rst        = 1'b0;
    req1_valid = 1'b0;
    req0_data  = sp_v[0];
    #1;
    check("idle_owner", 32'(owner), 32'd0);
    check("idle_wr_en", 32'(fifo_wr_en), 32'd0);
    check("idle_din", 32'(fifo_din), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      req0_data = sp_v[i];
      #1;
      check("sp_owner", 32'(owner), 32'd1);
      check("sp_wr_en", 32'(fifo_wr_en), 32'd1);
      check("sp_din", 32'(fifo_din), 32'(sp_v[i]));
      check("sp_ready", 32'({req1_ready, req0_ready}), 32'd1);
    end
    tick();
    req0_valid = 1'b0;
    #1;
    check("sp_tail_wr_en", 32'(fifo_wr_en), 32'd0);
    tick();
    check("sp_end_owner", 32'(owner), 32'd0);

    // Contention: alternating bursts of four with no bubbles
    apply_reset();
    run(8, 0, 8'h10, 8, 8'h20, 1000, 0, 60);
    check("cont_count", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16; i++) check("cont_data", 32'(got[i]), 32'(cont_v[i]));
    check("cont_first_cyc", 32'(gcyc[0]), 32'd1);
    check("cont_span", 32'(gcyc[15] - gcyc[0]), 32'd15);
`ifdef FIFO_ARB_STATS_EN
    check("stat_cnt0", 32'(grant_cnt0), 32'd8);
    check("stat_cnt1", 32'(grant_cnt1), 32'd8);
`endif

    // Full stall mid-burst must hold the beat count and the grant
    run(4, 0, 8'h30, 2, 8'h40, 2, 3, 60);
    check("full_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6; i++) check("full_data", 32'(got[i]), 32'(full_v[i]));
    check("full_resume_cyc", 32'(gcyc[1]), 32'd5);

    // Drop-out: req1 leaves after one beat, waiting req0 takes over next edge
    run(2, 1, 8'h60, 1, 8'h50, 1000, 0, 40);
    check("drop_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++) check("drop_data", 32'(got[i]), 32'(drop_v[i]));
    check("drop_handover_cyc", 32'(gcyc[1]), 32'd3);

    // Reset in the middle of a req1 burst
    tick();
    req1_valid = 1'b1;
    req1_data  = 8'h70;
    #1;
    check("mr_idle_owner", 32'(owner), 32'd0);
    tick();
    check("mr_owner1", 32'(owner), 32'd2);
    check("mr_din0", 32'(fifo_din), 32'h70);
    tick();
    req1_data = 8'h71;
    #1;
    check("mr_din1", 32'(fifo_din), 32'h71);
    tick();
    rst        = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 8'h80;
    req1_data  = 8'h72;
    tick();
    rst = 1'b0;
    #1;
    check("mr_rst_owner", 32'(owner), 32'd0);
    check("mr_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("mr_rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    tick();
    check("mr_regrant_owner", 32'(owner), 32'd1);
    check("mr_regrant_din", 32'(fifo_din), 32'h80);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();

`ifdef FIFO_ARB_STATS_EN
    // Saturation: preset counter stops at all-ones
    check("sat_preset", 32'(sat_cnt), 32'hFFFD);
    sat_inc = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    sat_inc = 1'b0;
    tick();
    check("sat_hold", 32'(sat_cnt), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
